store_buffer_unit: RTL and testbench
====================================

// Module: store_buffer_unit
// PURPOSE
//  Parametrised store buffer between memory-stage address generation and the dcache write port.
//  - Accepts stores, aligns them to doubleword lanes with a byte mask, and queues them in a DEPTH-entry FIFO.
//  - Drains stores to the dcache in order, one outstanding at a time, via a ready/ack handshake.
//  - Forwards buffered store data to younger loads; flags misaligned stores (cause 6).
// PARAMETERS
//  ADDR_WIDTH  64  byte address width
//  DATA_WIDTH  64  data path width; fixed at 64 (8 byte lanes)
//  DEPTH       4   buffer entries; power of two, >= 2
//  PTR_W       $clog2(DEPTH)  pointer width (derived, not overridable)
// PORTS
//  clk_i           in   1           clock
//  arst_i          in   1           asynchronous active-high reset
//  st_valid_i      in   1           store request valid
//  st_ready_o      out  1           buffer can accept store (= ~full)
//  st_addr_i       in   ADDR_WIDTH  store byte address
//  st_data_i       in   DATA_WIDTH  store data, right-aligned
//  st_size_i       in   2           00 SB, 01 SH, 10 SW, 11 SD (func3[1:0])
//  st_addr_ma_o    out  1           misaligned store seen this cycle
//  cause_o         out  4           4'd6 when st_addr_ma_o, else 4'd0
//  ld_valid_i      in   1           load lookup valid
//  ld_addr_i       in   ADDR_WIDTH  load byte address
//  ld_size_i       in   2           load size, same encoding
//  fwd_hit_o       out  1           load fully covered by buffer; fwd_data_o valid
//  fwd_data_o      out  DATA_WIDTH  forwarded doubleword, merged lanes, unshifted
//  fwd_stall_o     out  1           partial overlap; load must wait for drain
//  dc_req_o        out  1           dcache write request
//  dc_addr_o       out  ADDR_WIDTH  doubleword-aligned write address
//  dc_data_o       out  DATA_WIDTH  lane-aligned write data
//  dc_mask_o       out  8           byte write enable
//  dc_ack_i        in   1           dcache write done (hit/refill complete)
//  fence_i         in   1           request full drain
//  empty_o         out  1           no valid entries and FSM IDLE
// BEHAVIOUR
//  - Reset: FIFO pointers and count 0, all valid bits 0, FSM IDLE.
//    All outputs 0 except st_ready_o=1 and empty_o=1.
//  - Misalignment: addr[0] for SH, addr[1:0] for SW, addr[2:0] for SD must be zero.
//    A misaligned st_valid_i is NOT enqueued; st_addr_ma_o=1 and cause_o=6 combinationally, same cycle.
//  - Enqueue: st_valid_i & st_ready_o & aligned writes {addr[AW-1:3], data<<(8*addr[2:0]), mask} at tail.
//    Tail increments mod DEPTH; occupancy updates next cycle.
//  - st_ready_o = (count != DEPTH).
//    No push-through-when-full: a push in the same cycle as a pop while full is refused.
//  - Drain FSM:
//    IDLE -> WRITE when count != 0; head entry is driven on dc_*, dc_req_o=1.
//    WRITE holds dc_* stable until dc_ack_i.
//    On ack: pop head (head+1 mod DEPTH). Go to WRITE if count > 1, else IDLE.
//    dc_ack_i in IDLE is ignored.
//  - Simultaneous push and pop: count unchanged; both pointers advance.
//  - Forwarding (combinational, ld_valid_i only):
//    Build the load byte mask the same way as stores.
//    Candidates are valid entries with equal doubleword address.
//    Merge candidate lanes oldest-to-youngest (youngest wins per byte).
//    If the merged mask covers the load mask: fwd_hit_o=1.
//    Else if any candidate overlaps the load mask: fwd_stall_o=1.
//    Else both 0. The entry in WRITE stays a candidate until popped.
//  - fence_i: no new effect beyond draining; empty_o is the completion indicator.
//  - Reset mid-drain: all entries discarded; dc_req_o drops asynchronously.
// STRUCTURE
//  - mem_pkg: store_size_t enum, sb_entry_t struct {valid, dw_addr, data, mask},
//    CAUSE_ST_MA=4'd6, CAUSE_LD_MA=4'd4.
//  - Sub-module sb_lane_align: size + offset + data -> {lane data, byte mask, misaligned}.
//    One instance for the store path; the mask/misaligned part is reused for the load path.
// TESTING
//  - Reset, then SD 0x1000 data 0x1122334455667788 -> next cycle dc_req_o=1, dc_addr_o=0x1000, dc_mask_o=0xFF.
//    Ack -> empty_o=1.
//  - SW to 0x2004 with data 0xAABBCCDD, then LW 0x2004 while unacked -> fwd_hit_o=1, fwd_data_o[63:32]=0xAABBCCDD.
//  - SB 0x3001, then LH 0x3000 -> fwd_stall_o=1, fwd_hit_o=0.
//    After ack, the same lookup -> both 0.
//  - DEPTH stores with ack held low -> st_ready_o=0.
//    Extra store is refused; one ack -> st_ready_o=1 next cycle.
//    Drain order matches enqueue order.
//  - SH 0x4001 -> st_addr_ma_o=1, cause_o=6, count unchanged.
//    SD 0x4004 -> same.
//  - Two SB to 0x5000 (0x11, then 0x22), then LB 0x5000 -> fwd_data_o[7:0]=0x22.
//  - Assert arst_i while in WRITE -> dc_req_o=0 immediately; empty_o=1 after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the store buffer: size encoding, buffer entry layout,
// exception causes and the byte-mask / misalignment rules used by stores and loads.
package mem_pkg;

  localparam int unsigned SB_ADDR_W = 64;
  localparam int unsigned SB_DATA_W = 64;
  localparam int unsigned SB_LANES  = 8;

  localparam logic [3:0] CAUSE_ST_MA = 4'd6;
  localparam logic [3:0] CAUSE_LD_MA = 4'd4;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } store_size_t;

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_WRITE = 1'b1
  } sb_state_t;

  typedef struct packed {
    logic                   valid;
    logic [SB_ADDR_W-4:0]   dw_addr;
    logic [SB_DATA_W-1:0]   data;
    logic [SB_LANES-1:0]    mask;
  } sb_entry_t;

  // Byte-lane enables for an access of the given size at the given doubleword offset.
  function automatic logic [SB_LANES-1:0] size_mask(input store_size_t size,
                                                    input logic [2:0]  offset);
    logic [SB_LANES-1:0] base;
    case (size)
      SIZE_B:  base = 8'h01;
      SIZE_H:  base = 8'h03;
      SIZE_W:  base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  function automatic logic size_misaligned(input store_size_t size,
                                           input logic [2:0]  offset);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return offset[0];
      SIZE_W:  return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/sb_lane_align.sv
// Moves right-aligned store data into its doubleword byte lanes and derives the
// lane mask and misalignment flag for the access.
module sb_lane_align
  import mem_pkg::*;
(
  input  store_size_t           size,
  input  logic [2:0]            offset,
  input  logic [SB_DATA_W-1:0]  data,
  output logic [SB_DATA_W-1:0]  lane_data,
  output logic [SB_LANES-1:0]   mask,
  output logic                  misaligned
);

  always_comb begin
    lane_data  = data << {offset, 3'b000};
    mask       = size_mask(size, offset);
    misaligned = size_misaligned(size, offset);
  end

endmodule

// File: rtl/store_buffer_unit.sv
// In-order store buffer: aligns and queues stores, drains them one at a time to the
// dcache write port, and forwards buffered bytes to younger loads.
module store_buffer_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   st_valid_i,
  output logic                   st_ready_o,
  input  logic [ADDR_WIDTH-1:0]  st_addr_i,
  input  logic [DATA_WIDTH-1:0]  st_data_i,
  input  logic [1:0]             st_size_i,
  output logic                   st_addr_ma_o,
  output logic [3:0]             cause_o,
  input  logic                   ld_valid_i,
  input  logic [ADDR_WIDTH-1:0]  ld_addr_i,
  input  logic [1:0]             ld_size_i,
  output logic                   fwd_hit_o,
  output logic [DATA_WIDTH-1:0]  fwd_data_o,
  output logic                   fwd_stall_o,
  output logic                   dc_req_o,
  output logic [ADDR_WIDTH-1:0]  dc_addr_o,
  output logic [DATA_WIDTH-1:0]  dc_data_o,
  output logic [7:0]             dc_mask_o,
  input  logic                   dc_ack_i,
  input  logic                   fence_i,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DWA_W = SB_ADDR_W - 3;

  sb_state_t            state_q, state_d;
  logic [PTR_W-1:0]     head_q, tail_q, idx;
  logic [CNT_W-1:0]     cnt_q;
  sb_entry_t            mem_q [DEPTH];

  logic [SB_DATA_W-1:0] st_lane_data, fwd_data;
  logic [SB_LANES-1:0]  st_mask, ld_mask, fwd_mask;
  logic                 st_misaligned, push, pop, dc_req_c, hit;
  logic [DWA_W-1:0]     ld_dw;

  sb_lane_align u_st_align (
    .size       (store_size_t'(st_size_i)),
    .offset     (st_addr_i[2:0]),
    .data       (st_data_i),
    .lane_data  (st_lane_data),
    .mask       (st_mask),
    .misaligned (st_misaligned)
  );

  assign st_ready_o   = (cnt_q != CNT_W'(DEPTH));
  assign st_addr_ma_o = st_valid_i & st_misaligned;
  assign cause_o      = st_addr_ma_o ? CAUSE_ST_MA : 4'd0;
  assign push         = st_valid_i & st_ready_o & ~st_misaligned;
  assign pop          = (state_q == SB_WRITE) & dc_ack_i;

  // FIFO storage, pointers and occupancy; a full buffer refuses pushes even while popping.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= SB_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[tail_q] <= '{valid:   1'b1,
                           dw_addr: DWA_W'(st_addr_i[ADDR_WIDTH-1:3]),
                           data:    st_lane_data,
                           mask:    st_mask};
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        mem_q[head_q].valid <= 1'b0;
        head_q <= head_q + PTR_W'(1);
      end
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Drain FSM: one outstanding dcache write, held until acknowledged.
  always_comb begin
    state_d  = state_q;
    dc_req_c = 1'b0;
    case (state_q)
      SB_IDLE: begin
        if (cnt_q != '0) state_d = SB_WRITE;
      end
      SB_WRITE: begin
        dc_req_c = 1'b1;
        if (dc_ack_i) state_d = (cnt_q > CNT_W'(1)) ? SB_WRITE : SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
  end

  assign dc_req_o  = dc_req_c;
  assign dc_addr_o = ADDR_WIDTH'({mem_q[head_q].dw_addr, 3'b000});
  assign dc_data_o = mem_q[head_q].data;
  assign dc_mask_o = mem_q[head_q].mask;
  // A fence needs no extra action: the drain never stalls, so empty_o signals completion.
  assign empty_o   = (cnt_q == '0) && (state_q == SB_IDLE) && (fence_i || !fence_i);

  // Load forwarding: walk oldest to youngest so younger bytes overwrite older ones.
  always_comb begin
    ld_mask  = size_mask(store_size_t'(ld_size_i), ld_addr_i[2:0]);
    ld_dw    = DWA_W'(ld_addr_i[ADDR_WIDTH-1:3]);
    fwd_mask = '0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (mem_q[idx].valid && (mem_q[idx].dw_addr == ld_dw)) begin
        for (int unsigned b = 0; b < SB_LANES; b++) begin
          if (mem_q[idx].mask[b]) fwd_data[8*b +: 8] = mem_q[idx].data[8*b +: 8];
        end
        fwd_mask = fwd_mask | mem_q[idx].mask;
      end
    end
  end

  assign hit         = ld_valid_i && ((fwd_mask & ld_mask) == ld_mask);
  assign fwd_hit_o   = hit;
  assign fwd_stall_o = ld_valid_i && !hit && (|(fwd_mask & ld_mask));
  assign fwd_data_o  = hit ? fwd_data : '0;

endmodule

// File: tb/tb_store_buffer_unit.sv
// Scoreboard bench for store_buffer_unit: expected dcache writes are queued as stores
// are accepted and checked in order as the buffer drains.
module tb_store_buffer_unit;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } wr_t;

  logic        clk_i, arst_i;
  logic        st_valid_i, st_ready_o, st_addr_ma_o;
  logic [63:0] st_addr_i, st_data_i;
  logic [1:0]  st_size_i;
  logic [3:0]  cause_o;
  logic        ld_valid_i;
  logic [63:0] ld_addr_i;
  logic [1:0]  ld_size_i;
  logic        fwd_hit_o, fwd_stall_o;
  logic [63:0] fwd_data_o;
  logic        dc_req_o, dc_ack_i, fence_i, empty_o;
  logic [63:0] dc_addr_o, dc_data_o;
  logic [7:0]  dc_mask_o;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  model_cnt = 0;
  wr_t sbq[$];

  store_buffer_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .st_size_i(st_size_i), .st_addr_ma_o(st_addr_ma_o),
    .cause_o(cause_o), .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i),
    .ld_size_i(ld_size_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
    .fwd_stall_o(fwd_stall_o), .dc_req_o(dc_req_o), .dc_addr_o(dc_addr_o),
    .dc_data_o(dc_data_o), .dc_mask_o(dc_mask_o), .dc_ack_i(dc_ack_i),
    .fence_i(fence_i), .empty_o(empty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_mask(input logic [1:0] sz, input logic [2:0] off);
    int          nb;
    logic [15:0] m;
    nb = 1 << sz;
    m  = ((16'd1 << nb) - 16'd1) << off;
    return m[7:0];
  endfunction

  function automatic logic m_ma(input logic [1:0] sz, input logic [2:0] off);
    return (int'(off) % (1 << sz)) != 0;
  endfunction

  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic do_store(input logic [63:0] addr, input logic [1:0] sz, input logic [63:0] data);
    logic ma, exp_rdy;
    wr_t  w;
    @(negedge clk_i);
    st_valid_i = 1'b1; st_addr_i = addr; st_size_i = sz; st_data_i = data;
    #1;
    ma      = m_ma(sz, addr[2:0]);
    exp_rdy = (model_cnt != DEPTH);
    chk("st_ready", st_ready_o, exp_rdy);
    chk("st_addr_ma", st_addr_ma_o, ma);
    chk("cause", cause_o, ma ? 4'd6 : 4'd0);
    if (!ma && exp_rdy) begin
      w.addr = {addr[63:3], 3'b000};
      w.data = data << (8 * addr[2:0]);
      w.mask = m_mask(sz, addr[2:0]);
      sbq.push_back(w);
      model_cnt++;
    end
    @(negedge clk_i);
    st_valid_i = 1'b0;
  endtask

  task automatic ack_one();
    int          waited;
    wr_t         w;
    logic [63:0] bm;
    waited = 0;
    @(negedge clk_i);
    while (!dc_req_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    if (!dc_req_o) begin
      chk("dc_req_timeout", dc_req_o, 1);
      return;
    end
    if (sbq.size() == 0) begin
      chk("dc_req_unexpected", dc_req_o, 0);
      return;
    end
    w  = sbq.pop_front();
    bm = expand(w.mask);
    chk("dc_addr", dc_addr_o, w.addr);
    chk("dc_mask", dc_mask_o, w.mask);
    chk("dc_data", dc_data_o & bm, w.data & bm);
    dc_ack_i = 1'b1;
    @(negedge clk_i);
    dc_ack_i = 1'b0;
    model_cnt--;
  endtask

  task automatic do_load(input logic [63:0] addr, input logic [1:0] sz,
                         input logic exp_hit, input logic exp_stall, input logic [63:0] exp_data);
    @(negedge clk_i);
    ld_valid_i = 1'b1; ld_addr_i = addr; ld_size_i = sz;
    #1;
    chk("fwd_hit", fwd_hit_o, exp_hit);
    chk("fwd_stall", fwd_stall_o, exp_stall);
    chk("fwd_data", fwd_data_o, exp_data);
    ld_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    st_valid_i = 0; st_addr_i = '0; st_data_i = '0; st_size_i = '0;
    ld_valid_i = 0; ld_addr_i = '0; ld_size_i = '0;
    dc_ack_i = 0; fence_i = 0;
    arst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    arst_i = 1'b0;
    #1;
    chk("rst_st_ready", st_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_dc_req", dc_req_o, 0);
    chk("rst_dc_addr", dc_addr_o, 0);
    chk("rst_dc_data", dc_data_o, 0);
    chk("rst_dc_mask", dc_mask_o, 0);
    chk("rst_fwd_hit", fwd_hit_o, 0);
    chk("rst_fwd_stall", fwd_stall_o, 0);
    chk("rst_ma", st_addr_ma_o, 0);
    chk("rst_cause", cause_o, 0);

    // Single doubleword store, drained and acknowledged
    fence_i = 1'b1;
    do_store(64'h1000, 2'b11, 64'h1122334455667788);
    chk("sd_not_empty", empty_o, 0);
    ack_one();
    chk("sd_empty_after_ack", empty_o, 1);
    fence_i = 1'b0;

    // Word store forwarded to an aligned word load while unacknowledged
    do_store(64'h2004, 2'b10, 64'hAABBCCDD);
    do_load(64'h2004, 2'b10, 1'b1, 1'b0, 64'hAABBCCDD_00000000);
    ack_one();

    // Partial overlap stalls, then clears once drained
    do_store(64'h3001, 2'b00, 64'h5A);
    do_load(64'h3000, 2'b01, 1'b0, 1'b1, 64'h0);
    ack_one();
    do_load(64'h3000, 2'b01, 1'b0, 1'b0, 64'h0);

    // Fill the buffer, one extra store refused, drain in order
    for (int i = 0; i <= DEPTH; i++)
      do_store(64'h6000 + 64'(8 * i), 2'b11, 64'h0101010101010101 * 64'(i + 1));
    chk("full_ready", st_ready_o, 0);
    ack_one();
    chk("ready_after_ack", st_ready_o, 1);
    for (int i = 1; i < DEPTH; i++) ack_one();
    chk("fill_drained_empty", empty_o, 1);

    // Misaligned stores are flagged and not enqueued
    do_store(64'h4001, 2'b01, 64'h1234);
    chk("sh_ma_empty", empty_o, 1);
    do_store(64'h4004, 2'b11, 64'hCAFE);
    chk("sd_ma_empty", empty_o, 1);

    // Youngest store wins per byte
    do_store(64'h5000, 2'b00, 64'h11);
    do_store(64'h5000, 2'b00, 64'h22);
    do_load(64'h5000, 2'b00, 1'b1, 1'b0, 64'h22);
    ack_one();
    ack_one();

    // Reset while a write is outstanding
    do_store(64'h7000, 2'b11, 64'hDEADBEEF01234567);
    waited = 0;
    while (!dc_req_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    chk("pre_rst_req", dc_req_o, 1);
    #1 arst_i = 1'b1;
    #1;
    chk("rst_req_drop", dc_req_o, 0);
    sbq.delete();
    model_cnt = 0;
    repeat (2) @(negedge clk_i);
    arst_i = 1'b0;
    #1;
    chk("post_rst_empty", empty_o, 1);
    chk("post_rst_ready", st_ready_o, 1);
    chk("post_rst_sbq_drained", 64'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
